// File: rtl/regfile_scoreboard.sv
// Integer register file for the pipelined core.
// Two combinational read ports, one write-back port with a link-data mode for
// JAL/JALR, and an optional write-first bypass from write-back to the read ports.
// Each register also carries a small pending-write counter. Decode uses these
// counters to stall on read-after-write hazards and to limit how many writes to
// one destination can be in flight at once.

module regfile_scoreboard #(
    parameter int              XLEN   = 32,
    parameter int              NREGS  = 32,
    parameter int              CNT_W  = 2,
    parameter int              BYPASS = 1,
    parameter logic [XLEN-1:0] RST_X1 = 32'h0000000C,
    parameter logic [XLEN-1:0] RST_X2 = 32'h0000000D,
    localparam int             AW     = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    output logic            issue_ready,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            wb_link,
    input  logic [XLEN-1:0] wb_pc,
    output logic [XLEN-1:0] last_link,
    output logic            sb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [CNT_W-1:0] cnt_q  [NREGS];
    logic [CNT_W-1:0] cnt_d  [NREGS];
    logic [XLEN-1:0]  last_link_q, last_link_d;
    logic             sb_err_q, sb_err_d;

    logic [XLEN-1:0]  wd;
    logic             wb_hit1, wb_hit2;
    logic             issue_acc;

    // Write-back data: link mode writes the return address, carry dropped.
    always_comb begin
        wd = wb_link ? (wb_pc + XLEN'(4)) : wb_data;
    end

    // Read ports and hazard flags. A valid write-back to the same register is
    // forwarded, and if it retires the last outstanding write the stall drops.
    // Busy is computed from the counter before this cycle's issue, so an
    // instruction never stalls on its own destination.
    always_comb begin
        wb_hit1 = wb_valid && (wb_rd == rs1_addr);
        wb_hit2 = wb_valid && (wb_rd == rs2_addr);

        if (rs1_addr == '0) begin
            rs1_data = '0;
        end else if ((BYPASS != 0) && wb_hit1) begin
            rs1_data = wd;
        end else begin
            rs1_data = regs_q[rs1_addr];
        end

        if (rs2_addr == '0) begin
            rs2_data = '0;
        end else if ((BYPASS != 0) && wb_hit2) begin
            rs2_data = wd;
        end else begin
            rs2_data = regs_q[rs2_addr];
        end

        rs1_busy = (rs1_addr != '0) && (cnt_q[rs1_addr] != '0) &&
                   !((BYPASS != 0) && wb_hit1 && (cnt_q[rs1_addr] == CNT_ONE));
        rs2_busy = (rs2_addr != '0) && (cnt_q[rs2_addr] != '0) &&
                   !((BYPASS != 0) && wb_hit2 && (cnt_q[rs2_addr] == CNT_ONE));
    end

    // Issue back-pressure: refuse only when the counter is full and nothing
    // retires to that register this cycle.
    always_comb begin
        issue_ready = !((issue_rd != '0) && (cnt_q[issue_rd] == CNT_MAX) &&
                        !(wb_valid && (wb_rd == issue_rd)));
        issue_acc   = issue_valid && issue_ready;
    end

    // Next-state for the register array, pending counters, link capture and
    // the sticky underflow flag. x0 is forced back to zero at the end.
    always_comb begin
        regs_d      = regs_q;
        cnt_d       = cnt_q;
        last_link_d = last_link_q;
        sb_err_d    = sb_err_q;

        if (wb_valid && (wb_rd != '0)) begin
            regs_d[wb_rd] = wd;
            if (wb_link) begin
                last_link_d = wd;
            end
        end

        for (int r = 1; r < NREGS; r++) begin
            if ((issue_acc && (issue_rd == AW'(r))) && !(wb_valid && (wb_rd == AW'(r)))) begin
                cnt_d[r] = cnt_q[r] + CNT_ONE;
            end else if ((wb_valid && (wb_rd == AW'(r))) && !(issue_acc && (issue_rd == AW'(r)))) begin
                if (cnt_q[r] == '0) begin
                    sb_err_d = 1'b1;
                end else begin
                    cnt_d[r] = cnt_q[r] - CNT_ONE;
                end
            end
        end

        regs_d[0] = '0;
        cnt_d[0]  = '0;
    end

    // State registers with synchronous active-low reset that discards all pending state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
            regs_q[1]   <= RST_X1;
            regs_q[2]   <= RST_X2;
            last_link_q <= '0;
            sb_err_q    <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            cnt_q       <= cnt_d;
            last_link_q <= last_link_d;
            sb_err_q    <= sb_err_d;
        end
    end

    assign last_link = last_link_q;
    assign sb_err    = sb_err_q;

endmodule
